aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Iterative AES-128/AES-256 encryption controller that time-shares one external round datapath (full round: shiftRow/subByte/mixColumn/addRoundKey; last round: no mixColumn) across all Nr rounds of a block. It accepts a plaintext block over a valid/ready handshake and performs the initial AddRoundKey itself. It then steps a round counter that addresses the round-key store and selects full vs. last round. It presents the ciphertext on a valid/ready output port. It sits between the block-input interface and the round datapath / key-schedule store.

## Interface
- DATA_WIDTH, 128, block width; only 128 supported.
- RK_ADDR_WIDTH, 4, round-key index width; must hold 0..14.
- CNT_WIDTH, 16, completed-block counter width.

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  block can be accepted this cycle.
- in_data  in  128  plaintext block.
- key_len  in  1  0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); sampled with in_data.
- rk_addr  out  RK_ADDR_WIDTH  round-key index to key store.
- rk_data  in  128  round key for rk_addr, combinational same cycle.
- rnd_state  out  128  state presented to round datapath.
- rnd_last  out  1  1 selects last-round path (no mixColumn).
- rnd_result  in  128  combinational round output for rnd_state/rk_data/rnd_last.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer takes ciphertext.
- out_data  out  128  ciphertext.
- busy  out  1  high in ROUND or DONE.
- blk_count  out  CNT_WIDTH  completed (handed-off) blocks, wraps.

## Operation
- States: IDLE, ROUND, DONE. Registers: state_reg[127:0], rnd_cnt[3:0], nr_reg[3:0], blk_count.
- IDLE: in_ready=1, rk_addr=0. On in_valid: state_reg <= in_data ^ rk_data; nr_reg <= key_len ? 14 : 10; rnd_cnt <= 1; go ROUND.
- ROUND: rk_addr=rnd_cnt; rnd_state=state_reg; rnd_last=(rnd_cnt==nr_reg). Each cycle state_reg <= rnd_result. If rnd_cnt==nr_reg go DONE, else rnd_cnt++.
- DONE: out_valid=1, out_data=state_reg, held stable until out_ready. On out_ready: blk_count++ (0xFFFF -> 0x0000), go IDLE.
- in_ready=0 in ROUND and DONE; key_len and in_data ignored there.
- rk_addr in DONE = nr_reg (don't-care to key store); rnd_last=0 outside ROUND.
- key_len changes while busy have no effect on the block in flight.
- out_data reflects state_reg in every state; only meaningful when out_valid=1.

## Timing
- Reset (rst low, async): state IDLE, in_ready=1, out_valid=0, busy=0, rnd_last=0, rk_addr=0, state_reg=0, out_data=0, rnd_state=0, rnd_cnt=0, nr_reg=10, blk_count=0.
- Reset mid-block: block dropped, no output, blk_count unchanged; release is synchronous to clk.
- Accept at edge E0; round k registered at edge Ek; out_valid high after edge E_Nr. Latency: 10 cycles (AES-128), 14 cycles (AES-256) from accept edge to out_valid.
- out_valid may stay high indefinitely (backpressure); state_reg frozen.
- Output handshake edge returns to IDLE; next accept earliest on following edge. Throughput: one block per Nr+2 cycles with out_ready tied high.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

## Test plan
- Reset: hold rst low with in_valid=1 -> in_ready=1, out_valid=0, busy=0, blk_count=0, no acceptance; after release, block accepted on first edge.
- AES-128 (bench with real round datapath and key store): key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_valid exactly 10 cycles after accept, out_data 69c4e0d86a7b0430d8cdb78070b4c55a; rk_addr sequence 0,1..10; rnd_last high only on rk_addr=10.
- AES-256: key 000102..1f, same pt -> out_valid 14 cycles after accept, out_data 8ea2b7ca516745bfeafc49904b496089; rk_addr 0..14.
- Backpressure: out_ready low 20 cycles -> out_valid and out_data stable, in_ready=0, blk_count unchanged; out_ready high -> blk_count+1, in_ready=1 next cycle.
- Mid-block: toggle key_len and in_data during ROUND -> no effect on result; assert rst at round 5 -> out_valid never rises, blk_count unchanged, IDLE.
- Counter wrap: preload via 65535 back-to-back AES-128 blocks (or force) -> blk_count 0xFFFF, next handoff -> 0x0000.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128/256 encryption controller.
// Latency: Nr cycles (10 or 14) from the accept edge to out_valid_o.
// Backpressure: holds the ciphertext, and stalls input, until out_ready_i.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   in_valid_i/in_ready_o     plaintext handshake (in_data_i, key_len_i)
//   rk_addr_o/rk_data_i       round-key store lookup (combinational return)
//   rnd_state_o/rnd_last_o    state and last-round select to the round datapath
//   rnd_result_i              combinational round datapath output
//   out_valid_o/out_ready_i   ciphertext handshake (out_data_o)
//   busy_o, blk_count_o       activity flag and completed-block counter
module aes_round_sequencer #(
  parameter int DATA_WIDTH    = 128,
  parameter int RK_ADDR_WIDTH = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [DATA_WIDTH-1:0]    in_data_i,
  input  logic                     key_len_i,
  output logic [RK_ADDR_WIDTH-1:0] rk_addr_o,
  input  logic [DATA_WIDTH-1:0]    rk_data_i,
  output logic [DATA_WIDTH-1:0]    rnd_state_o,
  output logic                     rnd_last_o,
  input  logic [DATA_WIDTH-1:0]    rnd_result_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_WIDTH-1:0]    out_data_o,
  output logic                     busy_o,
  output logic [CNT_WIDTH-1:0]     blk_count_o
);

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                   fsm_q, fsm_d;
  logic [DATA_WIDTH-1:0]    state_q, state_d;
  logic [3:0]               rnd_cnt_q, rnd_cnt_d;
  logic [3:0]               nr_q, nr_d;
  logic [CNT_WIDTH-1:0]     blk_count_q, blk_count_d;

  // All handshake/control outputs are registered; their next values are
  // computed alongside the state transition so they line up with it.
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;
  logic                     rnd_last_q, rnd_last_d;
  logic [RK_ADDR_WIDTH-1:0] rk_addr_q, rk_addr_d;

  logic [3:0]               rnd_cnt_inc;

  assign rnd_cnt_inc = rnd_cnt_q + 4'd1;

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rnd_cnt_d   = rnd_cnt_q;
    nr_d        = nr_q;
    blk_count_d = blk_count_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    rnd_last_d  = rnd_last_q;
    rk_addr_d   = rk_addr_q;

    unique case (fsm_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          // rk_addr_o is 0 here, so rk_data_i is round key 0: initial AddRoundKey.
          state_d    = in_data_i ^ rk_data_i;
          nr_d       = key_len_i ? NR_256 : NR_128;
          rnd_cnt_d  = 4'd1;
          fsm_d      = ST_ROUND;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          rk_addr_d  = RK_ADDR_WIDTH'(4'd1);
          rnd_last_d = 1'b0;    // Nr >= 10, so round 1 is never the last
        end
      end

      ST_ROUND: begin
        state_d = rnd_result_i;
        if (rnd_cnt_q == nr_q) begin
          fsm_d       = ST_DONE;
          out_valid_d = 1'b1;
          rnd_last_d  = 1'b0;
          rk_addr_d   = RK_ADDR_WIDTH'(nr_q);
        end else begin
          rnd_cnt_d  = rnd_cnt_inc;
          rk_addr_d  = RK_ADDR_WIDTH'(rnd_cnt_inc);
          rnd_last_d = (rnd_cnt_inc == nr_q);
        end
      end

      ST_DONE: begin
        if (out_ready_i) begin
          blk_count_d = blk_count_q + CNT_WIDTH'(1);
          fsm_d       = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          rk_addr_d   = '0;
        end
      end

      default: begin
        fsm_d       = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        rnd_last_d  = 1'b0;
        rk_addr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      rnd_cnt_q   <= 4'd0;
      nr_q        <= NR_128;
      blk_count_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rnd_last_q  <= 1'b0;
      rk_addr_q   <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rnd_cnt_q   <= rnd_cnt_d;
      nr_q        <= nr_d;
      blk_count_q <= blk_count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rnd_last_q  <= rnd_last_d;
      rk_addr_q   <= rk_addr_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign rnd_last_o  = rnd_last_q;
  assign rk_addr_o   = rk_addr_q;
  assign rnd_state_o = state_q;
  assign out_data_o  = state_q;
  assign blk_count_o = blk_count_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, key_len, rnd_last, out_valid, out_ready, busy;
  logic [127:0] in_data, rk_data, rnd_state, rnd_result, out_data;
  logic [3:0]   rk_addr;
  logic [15:0]  blk_count;
  logic [127:0] rk_mem [16];

  // narrow-counter instance used to exercise counter wrap in few cycles
  logic         in_valid_w, in_ready_w, rnd_last_w, out_valid_w, out_ready_w, busy_w;
  logic [127:0] rnd_state_w, out_data_w;
  logic [3:0]   rk_addr_w;
  logic [1:0]   blk_count_w;
  logic [127:0] zero128 = '0;
  logic [127:0] wrap_pt = 128'hdeadbeef;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  aes_round_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .key_len_i(key_len), .rk_addr_o(rk_addr), .rk_data_i(rk_data),
    .rnd_state_o(rnd_state), .rnd_last_o(rnd_last), .rnd_result_i(rnd_result),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .busy_o(busy), .blk_count_o(blk_count));

  aes_round_sequencer #(.CNT_WIDTH(2)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid_w), .in_ready_o(in_ready_w),
    .in_data_i(wrap_pt), .key_len_i(1'b0), .rk_addr_o(rk_addr_w), .rk_data_i(zero128),
    .rnd_state_o(rnd_state_w), .rnd_last_o(rnd_last_w), .rnd_result_i(rnd_state_w),
    .out_valid_o(out_valid_w), .out_ready_i(out_ready_w), .out_data_o(out_data_w),
    .busy_o(busy_w), .blk_count_o(blk_count_w));

  // ---------------- reference AES round datapath and key store ----------------
  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [2047:0] t;
    t = SBOX;
    return t[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sb(s[127 - 8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) t[rw + 4*c] = a[rw + 4*((c + rw) % 4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        logic [7:0] a0, a1, a2, a3;
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = t[i];
    return r ^ rk;
  endfunction

  task automatic expand(input logic [255:0] key, input logic k256);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    int nk, nr;
    nk = k256 ? 8 : 4;
    nr = k256 ? 14 : 10;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp  = subword({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = subword(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 16; r++)
      rk_mem[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  always_comb rk_data = rk_mem[rk_addr];
  always_comb rnd_result = aes_round(rnd_state, rk_data, rnd_last);

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic         k256;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           bp;      // cycles of out_ready low while out_valid is high
    bit           toggle;  // disturb in_data/key_len/in_valid during rounds
  } vec_t;

  vec_t vecs [5];

  task automatic run_block(input int v);
    vec_t t;
    int   nr;
    bit   ok;
    t  = vecs[v];
    nr = t.k256 ? 14 : 10;
    expand(t.key, t.k256);
    @(negedge clk);
    in_data = t.pt; key_len = t.k256; in_valid = 1'b1; out_ready = 1'b0;
    chk($sformatf("v%0d_idle_in_ready", v), in_ready, 1);
    chk($sformatf("v%0d_idle_rk_addr", v), rk_addr, 0);
    @(posedge clk);                       // accept edge E0
    ok = 1;
    for (int k = 1; k <= nr; k++) begin
      @(negedge clk);
      if (t.toggle) begin
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        key_len  = ~key_len;
        in_valid = ~in_valid;
      end else begin
        in_valid = 1'b0;
      end
      chk($sformatf("v%0d_rk_addr_r%0d", v, k), rk_addr, k);
      chk($sformatf("v%0d_rnd_last_r%0d", v, k), rnd_last, (k == nr));
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) ok = 0;
    end
    chk($sformatf("v%0d_round_flags", v), ok, 1);
    @(negedge clk);                       // after edge E_Nr
    in_valid = 1'b0;
    chk($sformatf("v%0d_out_valid", v), out_valid, 1);
    chk($sformatf("v%0d_out_data", v), out_data, t.ct);
    chk($sformatf("v%0d_done_flags", v), {in_ready, busy, rnd_last}, 3'b010);
    if (t.bp > 0) begin
      ok = 1;
      repeat (t.bp) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_data !== t.ct || in_ready !== 1'b0 ||
            blk_count !== 16'(exp_cnt)) ok = 0;
      end
      chk($sformatf("v%0d_backpressure_stable", v), ok, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    exp_cnt++;
    @(negedge clk);
    chk($sformatf("v%0d_blk_count", v), blk_count, 16'(exp_cnt));
    chk($sformatf("v%0d_back_idle", v), {in_ready, out_valid, busy}, 3'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  hits, first, second;
    bit  ok, found;

    vecs[0] = '{1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0};
    vecs[1] = '{1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 20, 1'b0};
    vecs[2] = '{1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 0, 1'b1};
    vecs[3] = '{1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 0, 1'b1};
    vecs[4] = '{1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 3, 1'b0};

    // reset held with a block offered: nothing accepted
    rst_n = 1'b0; out_ready = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b0;
    expand(vecs[0].key, vecs[0].k256);
    in_data = vecs[0].pt; key_len = 1'b0; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_blk_count", blk_count, 0);
    chk("rst_rk_addr", rk_addr, 0);
    chk("rst_rnd_last", rnd_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_rnd_state", rnd_state, 0);
    rst_n = 1'b1;
    @(posedge clk);                        // first edge after release accepts
    @(negedge clk);
    in_valid = 1'b0;
    chk("accept_first_edge_busy", busy, 1);
    chk("accept_first_edge_rk_addr", rk_addr, 1);
    chk("accept_initial_ark", rnd_state, vecs[0].pt ^ rk_mem[0]);

    // reset in the middle of round 5 drops the block
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midblk_round5_rk_addr", rk_addr, 5);
    rst_n = 1'b0;
    #1;
    chk("midblk_rst_flags", {in_ready, out_valid, busy, rnd_last}, 4'b1000);
    chk("midblk_rst_rk_addr", rk_addr, 0);
    chk("midblk_rst_blk_count", blk_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1;
    repeat (16) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) ok = 0;
    end
    chk("midblk_no_output", ok, 1);
    chk("midblk_blk_count", blk_count, 0);

    // directed vector table
    for (int v = 0; v < 5; v++) run_block(v);

    // back-to-back AES-128 with out_ready tied high
    expand(vecs[0].key, vecs[0].k256);
    @(negedge clk);
    in_data = vecs[0].pt; key_len = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    hits = 0; first = -1; second = -1;
    for (int c = 0; c < 40 && hits < 2; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (hits == 0) first = c;
        else second = c;
        hits++;
        chk($sformatf("tp_out_data_%0d", hits), out_data, vecs[0].ct);
        if (hits == 2) in_valid = 1'b0;
      end
    end
    chk("tp_latency", first, 10);
    chk("tp_interval", second - first, 12);
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt += 2;
    chk("tp_blk_count", blk_count, 16'(exp_cnt));

    // counter wrap on the narrow instance: all-ones then zero
    in_valid_w = 1'b1; out_ready_w = 1'b1;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (blk_count_w == 2'b11) begin found = 1; break; end
    end
    chk("wrap_reach_all_ones", found, 1);
    found = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid_w) begin found = 1; break; end
    end
    chk("wrap_handoff_seen", found, 1);
    chk("wrap_before_handoff", blk_count_w, 2'b11);
    @(negedge clk);
    in_valid_w = 1'b0;
    chk("wrap_to_zero", blk_count_w, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
